// File: rtl/hex_display_drv.sv
// hex_display_drv: drives eight active-low 7-segment digits from the CPU out value.
// Ports: clck, rst_n (async, active-low), val[31:0] in;
//        busy, ovf, HEX0..HEX7[6:0] out (bit0 = seg a .. bit6 = seg g).
// Macro HEX_DISPLAY_DECIMAL_EN: defined selects the decimal double-dabble
// converter; undefined shows val directly as eight hex digits.
module hex_display_drv #(
    parameter int BLANK_LZ = 1
) (
    input  logic        clck,
    input  logic        rst_n,
    input  logic [31:0] val,
    output logic        busy,
    output logic        ovf,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3,
    output logic [6:0]  HEX4,
    output logic [6:0]  HEX5,
    output logic [6:0]  HEX6,
    output logic [6:0]  HEX7
);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        unique case (d)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Walk from the top digit down; while every digit seen so far is zero
    // the digit is blanked. HEX0 is always shown. keep disables blanking.
    function automatic logic [55:0] render(input logic [31:0] d,
                                           input logic keep);
        logic [55:0] s;
        logic        lead;
        s    = '0;
        lead = (BLANK_LZ != 0) && !keep;
        for (int i = 7; i >= 1; i--) begin
            if (d[4*i +: 4] != 4'd0)
                lead = 1'b0;
            s[7*i +: 7] = lead ? 7'h7F : seg7(d[4*i +: 4]);
        end
        s[6:0] = seg7(d[3:0]);
        return s;
    endfunction

    logic [55:0] seg_q;

    assign HEX0 = seg_q[6:0];
    assign HEX1 = seg_q[13:7];
    assign HEX2 = seg_q[20:14];
    assign HEX3 = seg_q[27:21];
    assign HEX4 = seg_q[34:28];
    assign HEX5 = seg_q[41:35];
    assign HEX6 = seg_q[48:42];
    assign HEX7 = seg_q[55:49];

`ifdef HEX_DISPLAY_DECIMAL_EN

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t      state;
    logic [31:0] last;
    logic [31:0] bin;
    logic [39:0] bcd;
    logic [4:0]  cnt;
    logic [39:0] adj;
    logic [71:0] sh;

    // Add-3 correction on every BCD nibble, then one left shift of the pair.
    always_comb begin
        adj = '0;
        for (int i = 0; i < 10; i++) begin
            if (bcd[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            else
                adj[4*i +: 4] = bcd[4*i +: 4];
        end
        sh = {adj, bin} << 1;
    end

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= '0;
            bin   <= '0;
            bcd   <= '0;
            cnt   <= '0;
            busy  <= 1'b0;
            ovf   <= 1'b0;
            seg_q <= render(32'd0, 1'b0);
        end else begin
            unique case (state)
                IDLE: begin
                    if (val != last) begin
                        last  <= val;
                        bin   <= val;
                        bcd   <= '0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    bcd <= sh[71:32];
                    bin <= sh[31:0];
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'd31)
                        state <= DONE;
                end
                default: begin
                    seg_q <= render(bcd[31:0], bcd[39:32] != 8'd0);
                    ovf   <= (bcd[39:32] != 8'd0);
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`else

    assign busy = 1'b0;
    assign ovf  = 1'b0;

    always_ff @(posedge clck or negedge rst_n) begin
        if (!rst_n)
            seg_q <= render(32'd0, 1'b0);
        else
            seg_q <= render(val, 1'b0);
    end

`endif

endmodule
